// File: rtl/hwag_gap_sync.sv
// Missing-tooth gap synchroniser: measures tooth periods from edge0, checks for the
// gap on edge1, and tracks tooth index and crank sync status for the angle generator.
module hwag_gap_sync #(
  parameter int PCNT_WIDTH = 24,
  parameter int TCNT_WIDTH = 8,
  parameter int TOOTH_NUM  = 60,
  parameter int GAP_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  edge0,
  input  logic                  edge1,
  output logic                  sync,
  output logic [TCNT_WIDTH-1:0] tooth_cnt,
  output logic                  gap_pulse,
  output logic                  sync_err,
  output logic                  stall,
  output logic [PCNT_WIDTH-1:0] period0,
  output logic [PCNT_WIDTH-1:0] period1,
  output logic [PCNT_WIDTH-1:0] period2,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_SYNC   = 2'd2
  } state_t;

  localparam logic [PCNT_WIDTH-1:0] PCNT_MAX   = '1;
  localparam logic [TCNT_WIDTH-1:0] LAST_TOOTH = TCNT_WIDTH'(TOOTH_NUM - GAP_NUM - 1);

  state_t                state;
  logic [PCNT_WIDTH-1:0] pcnt;
  logic [1:0]            cap_cnt;
  logic                  gap;
  logic                  saturate;

  // One extra bit on both sides so doubling period1 can never wrap.
  assign gap       = (cap_cnt == 2'd3) && ({1'b0, period0} > {period1, 1'b0});
  assign saturate  = (pcnt == PCNT_MAX) && !edge0;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pcnt      <= '0;
      cap_cnt   <= 2'd0;
      period0   <= '0;
      period1   <= '0;
      period2   <= '0;
      tooth_cnt <= '0;
      sync      <= 1'b0;
      gap_pulse <= 1'b0;
      sync_err  <= 1'b0;
      stall     <= 1'b0;
    end else if (ena) begin
      gap_pulse <= 1'b0;
      sync_err  <= 1'b0;

      if (edge0) begin
        pcnt <= PCNT_WIDTH'(1);
      end else if (pcnt != PCNT_MAX) begin
        pcnt <= pcnt + PCNT_WIDTH'(1);
      end

      if (saturate) begin
        // Engine stopped: drop all history so the restart must re-learn the wheel.
        stall     <= 1'b1;
        cap_cnt   <= 2'd0;
        state     <= ST_IDLE;
        tooth_cnt <= '0;
        sync      <= 1'b0;
        sync_err  <= (state == ST_SYNC);
      end else begin
        // Evaluation reads the pre-capture period registers when edges are back to back.
        if (edge1) begin
          case (state)
            ST_IDLE: begin
              if (cap_cnt == 2'd3) state <= ST_SEARCH;
            end
            ST_SEARCH: begin
              if (gap) begin
                state     <= ST_SYNC;
                sync      <= 1'b1;
                tooth_cnt <= '0;
                gap_pulse <= 1'b1;
              end
            end
            ST_SYNC: begin
              if (gap && (tooth_cnt == LAST_TOOTH)) begin
                tooth_cnt <= '0;
                gap_pulse <= 1'b1;
              end else if (gap || (tooth_cnt == LAST_TOOTH)) begin
                state     <= ST_SEARCH;
                sync      <= 1'b0;
                tooth_cnt <= '0;
                sync_err  <= 1'b1;
              end else begin
                tooth_cnt <= tooth_cnt + TCNT_WIDTH'(1);
              end
            end
            default: begin
              state <= ST_IDLE;
              sync  <= 1'b0;
            end
          endcase
        end

        if (edge0) begin
          stall   <= 1'b0;
          period0 <= pcnt;
          period1 <= period0;
          period2 <= period1;
          cap_cnt <= (cap_cnt == 2'd3) ? 2'd3 : cap_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hwag_gap_sync.sv
// Bench for hwag_gap_sync on an 8-bit period counter: directed 60-2 wheel table,
// stall/reset sequences, then random wheels against a time-stamp based model.
module tb_hwag_gap_sync;

  localparam int PW   = 8;
  localparam int TW   = 8;
  localparam int PMAX = 255;
  localparam int LAST = 57;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_SYNC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ena = 1'b1, edge0 = 1'b0, edge1 = 1'b0;
  logic          sync, gap_pulse, sync_err, stall;
  logic [TW-1:0] tooth_cnt;
  logic [PW-1:0] period0, period1, period2;
  logic [1:0]    state_dbg;

  hwag_gap_sync #(.PCNT_WIDTH(PW), .TCNT_WIDTH(TW), .TOOTH_NUM(60), .GAP_NUM(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .edge0(edge0), .edge1(edge1),
    .sync(sync), .tooth_cnt(tooth_cnt), .gap_pulse(gap_pulse), .sync_err(sync_err),
    .stall(stall), .period0(period0), .period1(period1), .period2(period2),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Reference model: periods are differences of edge timestamps, history is a queue.
  logic [PW-1:0] exp_q[$];
  int  now = 0;
  int  m_ref, m_cap, m_mode, m_tooth;
  int  hist[$];
  bit  m_sync, m_gp, m_err, m_stall;
  bit  prev_e0 = 1'b0;

  function automatic void model_reset();
    m_ref = now + 1;
    m_cap = 0; m_mode = M_IDLE; m_tooth = 0;
    hist = '{0, 0, 0};
    m_sync = 0; m_gp = 0; m_err = 0; m_stall = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step(bit e0, bit e1, bit en);
    int seen;
    bit is_gap;
    if (!en) begin
      m_ref++;
      return;
    end
    seen = now - m_ref;
    if (seen > PMAX) seen = PMAX;
    m_gp = 0;
    m_err = 0;
    if (!e0 && seen == PMAX) begin
      m_stall = 1;
      m_cap = 0;
      if (m_mode == M_SYNC) m_err = 1;
      m_mode = M_IDLE;
      m_tooth = 0;
    end else begin
      if (e1) begin
        is_gap = (m_cap == 3) && (hist[0] > 2 * hist[1]);
        if (m_mode == M_IDLE) begin
          if (m_cap == 3) m_mode = M_SEARCH;
        end else if (m_mode == M_SEARCH) begin
          if (is_gap) begin m_mode = M_SYNC; m_tooth = 0; m_gp = 1; end
        end else begin
          if (is_gap && m_tooth == LAST) begin
            m_tooth = 0; m_gp = 1;
          end else if (is_gap || m_tooth == LAST) begin
            m_tooth = 0; m_err = 1; m_mode = M_SEARCH;
          end else begin
            m_tooth++;
          end
        end
      end
      if (e0) begin
        hist.push_front(seen);
        void'(hist.pop_back());
        if (m_cap < 3) m_cap++;
        m_ref = now;
        m_stall = 0;
        exp_q.push_back(PW'(seen));
      end
    end
    m_sync = (m_mode == M_SYNC);
  endfunction

  function automatic void compare_all();
    chk("sync", int'(sync), int'(m_sync));
    chk("tooth_cnt", int'(tooth_cnt), m_tooth);
    chk("gap_pulse", int'(gap_pulse), int'(m_gp));
    chk("sync_err", int'(sync_err), int'(m_err));
    chk("stall", int'(stall), int'(m_stall));
    chk("period1", int'(period1), hist[1]);
    chk("period2", int'(period2), hist[2]);
    chk("state", int'(state_dbg), m_mode);
    if (exp_q.size() > 0) chk("cap_period", int'(period0), int'(exp_q.pop_front()));
  endfunction

  // driver tasks
  task automatic cyc(input bit e0, input bit en);
    edge0 = e0 & en;
    edge1 = prev_e0;
    ena   = en;
    prev_e0 = e0 & en;
    @(posedge clk);
    now++;
    #1;
    model_step(edge0, edge1, en);
    compare_all();
  endtask

  // Edge now, next edge n cycles later; 'off' cycles of ena=0 sit inside the interval.
  task automatic tooth(input int n, input int off);
    cyc(1'b1, 1'b1);
    for (int i = 1; i < n; i++) cyc(1'b0, !(off > 0 && i >= 2 && i < 2 + off));
  endtask

  task automatic finish_reset();
    edge0 = 1'b0; edge1 = 1'b0; ena = 1'b1; prev_e0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int n; int p0; bit sy; int tc; bit gp; bit er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int n, int p0, bit sy, int tc, bit gp, bit er);
    vec_t v;
    v.n = n; v.p0 = p0; v.sy = sy; v.tc = tc; v.gp = gp; v.er = er;
    tbl.push_back(v);
  endfunction

  initial begin
    #(2_000_000);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t_per, kind, at;

    // acquisition, wrap, early gap, re-acquire, missed gap, re-acquire (20-cycle teeth)
    add(20, 0, 0, 0, 0, 0);
    add(20, 20, 0, 0, 0, 0);
    add(20, 20, 0, 0, 0, 0);
    add(60, 20, 0, 0, 0, 0);
    add(20, 60, 1, 0, 1, 0);
    for (int k = 1; k <= 57; k++) add((k == 57) ? 60 : 20, 20, 1, k, 0, 0);
    add(20, 60, 1, 0, 1, 0);
    for (int k = 1; k <= 30; k++) add((k == 30) ? 60 : 20, 20, 1, k, 0, 0);
    add(20, 60, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) add((k == 4) ? 60 : 20, 20, 0, 0, 0, 0);
    add(20, 60, 1, 0, 1, 0);
    for (int k = 1; k <= 57; k++) add(20, 20, 1, k, 0, 0);
    add(60, 20, 0, 0, 0, 1);
    add(2, 60, 1, 0, 1, 0);

    #2 rst = 1'b0;
    #1;
    chk("rst_sync", int'(sync), 0);
    chk("rst_tooth", int'(tooth_cnt), 0);
    chk("rst_period0", int'(period0), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_state", int'(state_dbg), M_IDLE);
    finish_reset();

    foreach (tbl[i]) begin
      cyc(1'b1, 1'b1);
      chk("tbl_period0", int'(period0), tbl[i].p0);
      cyc(1'b0, 1'b1);
      chk("tbl_sync", int'(sync), int'(tbl[i].sy));
      chk("tbl_tooth", int'(tooth_cnt), tbl[i].tc);
      chk("tbl_gap_pulse", int'(gap_pulse), int'(tbl[i].gp));
      chk("tbl_sync_err", int'(sync_err), int'(tbl[i].er));
      for (int j = 2; j < tbl[i].n; j++) cyc(1'b0, 1'b1);
    end

    // stall while synced: counter saturates 255 cycles after the last edge
    cnt = 0;
    while (!stall && cnt < 400) begin
      cyc(1'b0, 1'b1);
      cnt++;
    end
    chk("stall_latency", cnt, 254);
    chk("stall_sync_err", int'(sync_err), 1);
    chk("stall_sync", int'(sync), 0);
    chk("stall_state", int'(state_dbg), M_IDLE);
    cyc(1'b0, 1'b1);
    chk("stall_err_once", int'(sync_err), 0);
    chk("stall_held", int'(stall), 1);
    repeat (10) cyc(1'b0, 1'b1);

    // restart: SEARCH only after the third capture
    cyc(1'b1, 1'b1);
    chk("stall_clear", int'(stall), 0);
    repeat (19) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("restart_idle", int'(state_dbg), M_IDLE);
    repeat (18) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("restart_search", int'(state_dbg), M_SEARCH);
    repeat (58) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("reacq_sync", int'(sync), 1);
    chk("reacq_gap_pulse", int'(gap_pulse), 1);
    repeat (18) cyc(1'b0, 1'b1);
    repeat (3) tooth(20, 0);

    // asynchronous reset in the middle of a cycle while synced
    chk("pre_rst_tooth", int'(tooth_cnt), 3);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_sync", int'(sync), 0);
    chk("mid_rst_tooth", int'(tooth_cnt), 0);
    chk("mid_rst_period0", int'(period0), 0);
    chk("mid_rst_state", int'(state_dbg), M_IDLE);
    finish_reset();

    // random wheels against the model
    for (int rev = 0; rev < 16; rev++) begin
      t_per = $urandom_range(6, 30);
      kind  = $urandom_range(0, 6);
      at    = $urandom_range(5, 50);
      for (int e = 0; e < 58; e++) begin
        if (e == 57 && kind != 3)        tooth(3 * t_per, 0);
        else if (kind == 2 && e == at)   tooth(3 * t_per, 0);
        else if (kind == 5 && (e == at || e == at + 1)) tooth(1, 0);
        else if (kind == 6 && e == at)   tooth(t_per + 4, 4);
        else                             tooth(t_per, 0);
      end
      if (kind == 4) tooth(300, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwag_gap_sync.md
Name: hwag_gap_sync

Overview:
- Downstream consumer of the VR capture stage's edge0/edge1 tooth-edge pulses.
- Measures the tooth period in clk cycles and keeps a 3-deep period history.
- Detects the missing-tooth gap of the trigger wheel, tracks tooth index and reports crankshaft sync status.
- Feeds the angle generator with sync, tooth_cnt and the last period.

Parameters:
- PCNT_WIDTH, 24, width of period counter and captured periods
- TCNT_WIDTH, 8, width of tooth counter
- TOOTH_NUM, 60, nominal teeth per revolution (incl. missing)
- GAP_NUM, 2, missing teeth in gap

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ena  in  1  global enable; all state frozen when 0
- edge0  in  1  one-cycle tooth-edge pulse
- edge1  in  1  edge0 delayed exactly one cycle
- sync  out  1  1 while in SYNC state
- tooth_cnt  out  TCNT_WIDTH  index of last tooth edge, 0 = edge ending gap
- gap_pulse  out  1  one-cycle pulse on accepted gap edge
- sync_err  out  1  one-cycle pulse on loss of sync
- stall  out  1  period counter saturated (engine stopped)
- period0  out  PCNT_WIDTH  last captured period
- period1  out  PCNT_WIDTH  previous period

Behaviour:
- Reset (rst=0, async): pcnt=0, period0/1/2=0, cap_cnt=0, tooth_cnt=0, state IDLE, all outputs 0.
- All registers update only when ena=1.
- Period counter:
  - On edge0: pcnt<=1.
  - Otherwise pcnt<=pcnt+1, saturating at all-ones.
  - Edges N cycles apart capture period N.
- Capture on edge0: period2<=period1, period1<=period0, period0<=pcnt; cap_cnt<=min(cap_cnt+1,3).
- Stall:
  - When pcnt==all-ones and no edge0: stall<=1, cap_cnt<=0, state<=IDLE, tooth_cnt<=0.
  - sync_err pulses if state was SYNC.
  - stall clears on next edge0.
  - The first period after stall/reset is garbage; it is counted but not trusted.
- Gap test, evaluated on edge1 using stable registers:
  - gap = (period0 > 2*period1), computed in PCNT_WIDTH+1 bits, no overflow.
  - Valid only when cap_cnt==3.
- State machine, transitions only on edge1 & ena:
  - IDLE: cap_cnt==3 -> SEARCH.
  - SEARCH: gap -> SYNC, tooth_cnt<=0, gap_pulse. Non-gap edge: stay, tooth_cnt unchanged.
  - SYNC, gap & tooth_cnt==TOOTH_NUM-GAP_NUM-1: tooth_cnt<=0, gap_pulse, stay SYNC.
  - SYNC, gap & tooth_cnt!=TOOTH_NUM-GAP_NUM-1 (early gap): sync_err, tooth_cnt<=0, -> SEARCH.
  - SYNC, no gap & tooth_cnt==TOOTH_NUM-GAP_NUM-1 (missed gap): sync_err, tooth_cnt<=0, -> SEARCH.
  - SYNC, otherwise: tooth_cnt<=tooth_cnt+1.
- sync is registered: goes 1 the cycle after the accepted gap edge1; goes 0 the cycle after sync_err.
- Simultaneous events:
  - Stall saturation cannot coincide with edge0; edge0 wins.
  - edge0 and edge1 asserted together (back-to-back edges): capture and evaluation both act, evaluation uses pre-capture registers.
- Latency: period0 valid 1 cycle after edge0; gap_pulse/sync_err/tooth_cnt update 1 cycle after edge1.
- ena=0 during an edge pulse: that edge is ignored entirely.

Test Plan:
- Reset mid-SYNC:
  - Stimulus: drive rst=0 asynchronously at any cycle.
  - Response: same cycle, sync=0, tooth_cnt=0, period0=0, state IDLE.
- Period capture:
  - Stimulus: edges every 20 cycles.
  - Response: period0=20, period1=20, no gap_pulse, state SEARCH after 3rd edge, sync=0.
- Acquire sync (60-2 wheel, 20-cycle teeth):
  - Stimulus: one 60-cycle interval.
  - Response: gap_pulse once, sync=1, tooth_cnt=0.
  - Stimulus: next 57 edges.
  - Response: tooth_cnt counts 1..57.
  - Stimulus: next 60-cycle gap.
  - Response: gap_pulse, tooth_cnt=0, no sync_err.
- Early gap:
  - Stimulus: in SYNC, insert 60-cycle gap at tooth_cnt=30.
  - Response: sync_err pulse, sync=0, state SEARCH.
  - Stimulus: subsequent correct gap.
  - Response: sync re-acquired.
- Missing gap:
  - Stimulus: in SYNC, uniform 20-cycle edge at tooth_cnt=57.
  - Response: sync_err, sync=0.
- Stall (PCNT_WIDTH=8):
  - Stimulus: stop edges.
  - Response: after pcnt reaches 255, stall=1, sync_err if synced, state IDLE.
  - Stimulus: edges resume.
  - Response: stall clears on first edge; SEARCH only after 3 captures.
